// File: rtl/fop_bist.sv
// rtl/fop_bist.sv - sweeps the 4-bit fop input space and cross-checks three fop implementations
// against each other and a golden truth table, reporting error count, first failing vector and pass/done.
module fop_bist #(
  parameter int unsigned DWELL = 50,
  parameter logic [15:0] TRUTH = 16'h29AF,
  parameter int unsigned ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [3:0]       vec,
  input  logic             out_g,
  input  logic             out_d,
  input  logic             out_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [3:0]       first_err_vec,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [15:0]      DWELL_LAST = 16'(DWELL - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [15:0]      dwell_q, dwell_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fev_valid_q, fev_valid_d;
  logic [3:0]       fev_q, fev_d;
  logic             mismatch_q, mismatch_d;

  logic             check;
  logic             fail;
  logic [ERR_W-1:0] err_upd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      dwell_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fev_valid_q <= 1'b0;
      fev_q       <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      dwell_q     <= dwell_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fev_valid_q <= fev_valid_d;
      fev_q       <= fev_d;
      mismatch_q  <= mismatch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    dwell_d     = dwell_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fev_valid_d = fev_valid_q;
    fev_d       = fev_q;
    mismatch_d  = 1'b0;

    check = (state_q == ST_RUN) && (dwell_q == DWELL_LAST);
    fail  = (out_g != out_d) || (out_d != out_b) || (out_g != TRUTH[vec_q]);

    // Saturating update, shared by the counter and the final pass decision.
    err_upd = err_q;
    if (fail && (err_q != ERR_MAX)) begin
      err_upd = err_q + ERR_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          busy_d      = 1'b1;
          vec_d       = '0;
          dwell_d     = '0;
          err_d       = '0;
          fev_valid_d = 1'b0;
          fev_d       = '0;
          pass_d      = 1'b0;
          done_d      = 1'b0;
        end
      end
      ST_RUN: begin
        dwell_d = dwell_q + 16'd1;
        if (check) begin
          err_d      = err_upd;
          mismatch_d = fail;
          if (fail && !fev_valid_q) begin
            fev_valid_d = 1'b1;
            fev_d       = vec_q;
          end
          if (vec_q != 4'd15) begin
            vec_d   = vec_q + 4'd1;
            dwell_d = '0;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_upd == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign vec             = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_valid = fev_valid_q;
  assign first_err_vec   = fev_q;
  assign mismatch        = mismatch_q;

endmodule

// File: tb/tb_fop_bist.sv
// tb/tb_fop_bist.sv - scoreboard bench for fop_bist: main instance (DWELL=50, ERR_W=5)
// and a short instance (DWELL=1, ERR_W=3) for saturation.
module tb_fop_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic [3:0] vec_a, vec_b, fe_a, fe_b;
  logic       og_a, od_a, ob_a, og_b, od_b, ob_b;
  logic       busy_a, done_a, pass_a, fv_a, mm_a;
  logic       busy_b, done_b, pass_b, fv_b, mm_b;
  logic [4:0] err_a;
  logic [2:0] err_b;
  int         mode_a, mode_b;
  logic [15:0] truth_v = 16'h29AF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fop_bist #(.DWELL(50), .TRUTH(16'h29AF), .ERR_W(5)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .vec(vec_a),
    .out_g(og_a), .out_d(od_a), .out_b(ob_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_valid(fv_a), .first_err_vec(fe_a), .mismatch(mm_a)
  );

  fop_bist #(.DWELL(1), .TRUTH(16'h29AF), .ERR_W(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .vec(vec_b),
    .out_g(og_b), .out_d(od_b), .out_b(ob_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_valid(fv_b), .first_err_vec(fe_b), .mismatch(mm_b)
  );

  // Fault modes: 0 all correct, 1 out_b stuck 0, 2 out_d inverted at vec 6, 3 all inverted.
  function automatic logic [2:0] fop_model(input int mode, input logic [3:0] v);
    logic t;
    logic g, d, b;
    t = truth_v[v];
    g = t; d = t; b = t;
    case (mode)
      1: b = 1'b0;
      2: if (v == 4'd6) d = ~t;
      3: begin g = ~t; d = ~t; b = ~t; end
      default: ;
    endcase
    return {g, d, b};
  endfunction

  assign {og_a, od_a, ob_a} = fop_model(mode_a, vec_a);
  assign {og_b, od_b, ob_b} = fop_model(mode_b, vec_b);

  typedef struct {
    int dcyc;
    int err;
    int fv;
    int fe;
    int pass;
  } exp_t;

  exp_t sw_a[$], sw_b[$];
  int   mm_qa[$], mm_qb[$];
  exp_t ea, eb;
  logic dpa = 1'b0, dpb = 1'b0;
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // mask bit v set means vector v is expected to fail its check.
  task automatic push_exp(input int inst, input int k, input int dw, input logic [15:0] mask, input int emax);
    exp_t e;
    int n;
    n = 0; e.fv = 0; e.fe = 0;
    for (int v = 0; v < 16; v++) begin
      if (mask[v]) begin
        n++;
        if (e.fv == 0) begin e.fv = 1; e.fe = v; end
        if (inst == 0) mm_qa.push_back(k + (v + 1) * dw);
        else           mm_qb.push_back(k + (v + 1) * dw);
      end
    end
    e.err  = (n > emax) ? emax : n;
    e.pass = (n == 0) ? 1 : 0;
    e.dcyc = k + 16 * dw;
    if (inst == 0) sw_a.push_back(e);
    else           sw_b.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mm_a) begin
      if (mm_qa.size() == 0) chk("mm_a_unexpected", cyc, -1);
      else                   chk("mm_a_cycle", cyc, mm_qa.pop_front());
    end
    if (done_a && !dpa) begin
      if (sw_a.size() == 0) chk("done_a_unexpected", cyc, -1);
      else begin
        ea = sw_a.pop_front();
        chk("done_a_cycle", cyc, ea.dcyc);
        chk("done_a_err", int'(err_a), ea.err);
        chk("done_a_pass", int'(pass_a), ea.pass);
        chk("done_a_fv", int'(fv_a), ea.fv);
        if (ea.fv != 0) chk("done_a_fe", int'(fe_a), ea.fe);
      end
    end
    if (mm_b) begin
      if (mm_qb.size() == 0) chk("mm_b_unexpected", cyc, -1);
      else                   chk("mm_b_cycle", cyc, mm_qb.pop_front());
    end
    if (done_b && !dpb) begin
      if (sw_b.size() == 0) chk("done_b_unexpected", cyc, -1);
      else begin
        eb = sw_b.pop_front();
        chk("done_b_cycle", cyc, eb.dcyc);
        chk("done_b_err", int'(err_b), eb.err);
        chk("done_b_pass", int'(pass_b), eb.pass);
        chk("done_b_fv", int'(fv_b), eb.fv);
        if (eb.fv != 0) chk("done_b_fe", int'(fe_b), eb.fe);
      end
    end
    dpa <= done_a;
    dpb <= done_b;
  end

  task automatic start_a_sweep(output int k);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget && !done_a; i++) @(negedge clk);
    chk("done_a_timeout", int'(done_a), 1);
  endtask

  task automatic run_a(input int mode, input logic [15:0] mask);
    int k;
    mode_a = mode;
    start_a_sweep(k);
    push_exp(0, k, 50, mask, 31);
    chk("start_busy", int'(busy_a), 1);
    chk("start_vec", int'(vec_a), 0);
    wait_done_a(900);
  endtask

  initial begin
    int k;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 0; mode_b = 3;
    repeat (3) @(negedge clk);
    chk("rst_vec", int'(vec_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_flags", int'({done_a, pass_a, fv_a, mm_a}), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_fe", int'(fe_a), 0);
    rst = 1'b0;

    // Clean sweep with a mid-sweep vec step check
    mode_a = 0;
    start_a_sweep(k);
    push_exp(0, k, 50, 16'h0000, 31);
    repeat (160) @(negedge clk);
    chk("mid_vec", int'(vec_a), 3);
    wait_done_a(900);

    run_a(1, 16'b0010_1001_1010_1111);
    run_a(2, 16'b0000_0000_0100_0000);

    // Consistent-but-wrong outputs, DWELL=1, ERR_W=3 saturation
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start_b = 1'b0;
    push_exp(1, k, 1, 16'hFFFF, 7);
    for (int i = 0; i < 40 && !done_b; i++) @(negedge clk);
    chk("done_b_timeout", int'(done_b), 1);

    // start held through the sweep, then relaunch from DONE
    mode_a = 1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    push_exp(0, k, 50, 16'b0010_1001_1010_1111, 31);
    wait_done_a(900);
    mode_a = 0;
    push_exp(0, cyc + 1, 50, 16'h0000, 31);
    @(posedge clk);
    #1;
    chk("relaunch_busy", int'(busy_a), 1);
    chk("relaunch_done", int'(done_a), 0);
    chk("relaunch_err", int'(err_a), 0);
    chk("relaunch_fv", int'(fv_a), 0);
    chk("relaunch_vec", int'(vec_a), 0);
    start_a = 1'b0;
    wait_done_a(900);

    // Reset mid-dwell at vec 9, then a fresh clean sweep
    mode_a = 0;
    start_a_sweep(k);
    push_exp(0, k, 50, 16'h0000, 31);
    for (int i = 0; i < 1000 && vec_a != 4'd9; i++) @(negedge clk);
    chk("reach_vec9", int'(vec_a), 9);
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_vec", int'(vec_a), 0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_flags", int'({done_a, pass_a, fv_a, mm_a}), 0);
    chk("abort_err", int'(err_a), 0);
    sw_a.delete();
    mm_qa.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_rst", int'(busy_a), 0);
    run_a(0, 16'h0000);

    repeat (5) @(negedge clk);
    chk("mm_a_left", mm_qa.size(), 0);
    chk("sw_a_left", sw_a.size(), 0);
    chk("mm_b_left", mm_qb.size(), 0);
    chk("sw_b_left", sw_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
